// File: rtl/adc_pkg.sv
// Constants and state encoding shared between adc_emulator and adc_interface.
package adc_pkg;

  localparam int              ADC_DATA_WIDTH  = 16;
  localparam int              ADC_CONV_CYCLES = 142;
  localparam int              ADC_SYNC_STAGES = 2;
  localparam logic [15:0]     ADC_IDLE_WORD   = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READY   = 2'd2,
    ST_SHIFT   = 2'd3
  } adc_state_e;

endpackage

// File: rtl/adc_emulator_if.sv
// Sample-word stream feeding the emulator: one word per conversion over valid/ready.
interface adc_emulator_if
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] sample_data_p;
  logic                  sample_valid_p;
  logic                  sample_ready_p;

  modport master (output sample_data_p, output sample_valid_p, input  sample_ready_p);
  modport slave  (input  sample_data_p, input  sample_valid_p, output sample_ready_p);
endinterface

// File: rtl/adc_emulator_async_edge_sync.sv
// Synchronizer chain for an asynchronous pin plus a single-edge detector.
// Rise detection is armed only after a genuine low level has been sampled.
module async_edge_sync
  import adc_pkg::*;
#(
  parameter int SYNC_STAGES = ADC_SYNC_STAGES,
  parameter bit DETECT_RISE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   last_q;
  logic                   armed_q;
  logic                   level_s;

  assign level_s = sync_q[SYNC_STAGES-1];

  // fill_q marks when the chain output is a real pin sample, so a level
  // already high at reset release never looks like a rising edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      fill_q  <= '0;
      last_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      last_q  <= level_s;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~level_s);
    end
  end

  assign edge_o = DETECT_RISE ? (armed_q & level_s & ~last_q) : (last_q & ~level_s);

endmodule

// File: rtl/adc_emulator.sv
// Serial ADC emulator: answers CNV/SCK from adc_interface and shifts out one
// sample word per conversion, MSB first, changing SDO after each SCK fall.
module adc_emulator
  import adc_pkg::*;
#(
  parameter int                    DATA_WIDTH  = ADC_DATA_WIDTH,
  parameter int                    CONV_CYCLES = ADC_CONV_CYCLES,
  parameter int                    SYNC_STAGES = ADC_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = ADC_IDLE_WORD
) (
  input  logic          clk210_p,
  input  logic          reset_p,
  input  logic          cnv_p,
  input  logic          sck_p,
  output logic          sdo_p,
  output logic          busy_p,
  output logic          underrun_p,
  output logic          overrun_p,
  adc_emulator_if.slave sample_if
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] CONV_ONE  = CW'(1);
  localparam logic [CW-1:0] CONV_ZERO = CW'(0);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);

  adc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         conv_cnt_q, conv_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic                  cnv_rise_s, sck_fall_s, start_s;

  async_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b1)) u_cnv_sync (
    .clk_i   (clk210_p),
    .rst_n_i (reset_p),
    .async_i (cnv_p),
    .edge_o  (cnv_rise_s)
  );

  async_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b0)) u_sck_sync (
    .clk_i   (clk210_p),
    .rst_n_i (reset_p),
    .async_i (sck_p),
    .edge_o  (sck_fall_s)
  );

  // State and datapath registers; reset drops SDO without waiting for a clock.
  always_ff @(posedge clk210_p or negedge reset_p) begin
    if (!reset_p) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      conv_cnt_q <= CONV_ZERO;
      bit_cnt_q  <= BIT_ZERO;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      conv_cnt_q <= conv_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state decode; CNV rise outranks SCK fall and restarts from READY/SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cnv_rise_s) state_d = ST_CONVERT;
        else            state_d = ST_IDLE;
      end
      ST_CONVERT: begin
        if (conv_cnt_q == CONV_ZERO) state_d = ST_READY;
        else                         state_d = ST_CONVERT;
      end
      ST_READY: begin
        if (cnv_rise_s)      state_d = ST_CONVERT;
        else if (sck_fall_s) state_d = ST_SHIFT;
        else                 state_d = ST_READY;
      end
      ST_SHIFT: begin
        if (cnv_rise_s)                                state_d = ST_CONVERT;
        else if (sck_fall_s && (bit_cnt_q == BIT_ZERO)) state_d = ST_IDLE;
        else                                           state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output decode; outputs are registered from the next state.
  always_comb begin
    start_s    = 1'b0;
    shreg_d    = shreg_q;
    conv_cnt_d = conv_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    if (cnv_rise_s && (state_q != ST_CONVERT)) begin
      start_s    = 1'b1;
      underrun_d = ~sample_if.sample_valid_p;
      overrun_d  = (state_q == ST_READY) || (state_q == ST_SHIFT);
      conv_cnt_d = CONV_LOAD;
      if (sample_if.sample_valid_p) shreg_d = sample_if.sample_data_p;
      else                          shreg_d = IDLE_WORD;
    end else begin
      case (state_q)
        ST_CONVERT: begin
          if (conv_cnt_q != CONV_ZERO) conv_cnt_d = conv_cnt_q - CONV_ONE;
          else                         bit_cnt_d  = BIT_LOAD;
        end
        ST_READY, ST_SHIFT: begin
          if (sck_fall_s) begin
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            if (bit_cnt_q != BIT_ZERO) bit_cnt_d = bit_cnt_q - BIT_ONE;
            else                       bit_cnt_d = BIT_ZERO;
          end else begin
            shreg_d = shreg_q;
          end
        end
        default: shreg_d = shreg_q;
      endcase
    end
    sdo_d  = ((state_d == ST_READY) || (state_d == ST_SHIFT)) ? shreg_d[DATA_WIDTH-1] : 1'b0;
    busy_d = (state_d == ST_CONVERT);
  end

  assign sample_if.sample_ready_p = start_s;
  assign sdo_p      = sdo_q;
  assign busy_p     = busy_q;
  assign underrun_p = underrun_q;
  assign overrun_p  = overrun_q;

endmodule

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
- Synthesizable model of the 16-bit serial ADC that sits on the far side of adc_interface: responds to CNV/SCK and drives SDO.
- Enables loopback and bring-up without the real converter: adc_interface pins route to this block through a board or internal wire.
- Sample words come from an upstream source, such as a pattern generator or BRAM playback, over a valid/ready handshake, one word per conversion.

Parameters:
DATA_WIDTH, 16, sample word width and number of SDO bits per conversion
CONV_CYCLES, 142, clk210 cycles from the detected CNV rise to data-ready (about 675 ns at 210 MHz); must be at least 1
SYNC_STAGES, 2, synchronizer flops on cnv_p and sck_p; must be at least 2
IDLE_WORD, 16'h8000, word loaded when no sample is valid at conversion start

Ports:
clk210_p  in  1  210 MHz system clock
reset_p  in  1  reset, asynchronous assert, active-low
cnv_p  in  1  CNV from adc_interface; asynchronous to clk210_p, synchronized internally
sck_p  in  1  SCK from adc_interface; asynchronous, synchronized internally
sdo_p  out  1  serial data to adc_interface, MSB first
sample_data_p  in  DATA_WIDTH  next sample word
sample_valid_p  in  1  sample_data_p is valid
sample_ready_p  out  1  one-cycle accept strobe; a transfer occurs when this is high together with sample_valid_p
busy_p  out  1  high in CONVERT
underrun_p  out  1  one-cycle pulse: conversion started without a valid sample
overrun_p  out  1  one-cycle pulse: CNV rise arrived while READY or SHIFT

Behaviour:
Reset (reset_p = 0):
- State IDLE; all outputs 0.
- Shift register cleared to 0; bit counter 0; synchronizer chains 0.
Edge detection:
- cnv_rise and sck_fall are computed from the last synchronizer stage against a one-cycle delayed copy.
- Pin-to-detect latency is SYNC_STAGES+1 cycles.
IDLE:
- sdo_p = 0.
- On cnv_rise: sample_ready_p = 1 for that cycle.
- If sample_valid_p = 1, latch sample_data_p; otherwise latch IDLE_WORD and pulse underrun_p.
- Load conv counter with CONV_CYCLES-1; next state CONVERT.
CONVERT:
- busy_p = 1; sdo_p = 0; counter decrements each cycle.
- At 0, go to READY. Duration is exactly CONVERT_CYCLES cycles.
- cnv_rise and sck_fall are ignored; no overrun is flagged.
READY:
- sdo_p = shreg[MSB]; bit counter = DATA_WIDTH-1.
- On sck_fall: shift left by 1 (LSB filled with 0), decrement bit counter; next state SHIFT.
SHIFT:
- sdo_p = shreg[MSB].
- Each sck_fall shifts left by 1.
- When a sck_fall arrives with bit counter = 0: sdo_p = 0 and state goes to IDLE.
- adc_interface samples on SCK rise, so each bit is stable across the rising edge.
- A total of DATA_WIDTH falling edges ends the word.
Simultaneous events:
- cnv_rise in READY or SHIFT: overrun_p pulses, the remaining bits are discarded, and a new conversion starts exactly as from IDLE, including the handshake.
- cnv_rise and sck_fall in the same cycle: cnv_rise wins.
Other rules:
- sample_ready_p is asserted only on the conversion-start cycle; it is never high in any other state.
- An asynchronous reset mid-SHIFT forces sdo_p = 0 immediately. After deassertion the block waits in IDLE for a fresh cnv_rise; a CNV level already high does not trigger.
- No arithmetic beyond the counters. The conv counter is $clog2(CONV_CYCLES) bits; the bit counter is $clog2(DATA_WIDTH) bits; both saturate-safe (no wrap).

Decomposition:
- Shared package adc_pkg: ADC_DATA_WIDTH = 16, ADC_CONV_CYCLES = 142, and the 2-bit state encoding (IDLE = 0, CONVERT = 1, READY = 2, SHIFT = 3). These constants are shared with adc_interface.
- One sub-module, async_edge_sync: parameterized SYNC_STAGES flop chain plus rise/fall detect. Instantiated twice, for cnv_p and sck_p.

Test Plan:
- Valid sample 16'hA5C3 held, single CNV pulse then 16 SCK cycles (SCK period at least 8 clk210 cycles) -> sample_ready_p pulses once; busy_p high for 142 cycles; sdo bits captured on SCK rise = 1010 0101 1100 0011; sdo_p = 0 afterwards.
- sample_valid_p = 0 at CNV -> underrun_p pulses once; received word = 16'h8000.
- Back-to-back conversions with source words 16'h0001 then 16'hFFFF -> two transfers in order; decoded words match; no overrun.
- CNV rise after 5 SCK falls of word 16'h1234 -> overrun_p pulse; new word 16'hBEEF is shifted complete and correct.
- SCK toggling during CONVERT -> ignored; the subsequent 16-bit read is still correct. reset_p asserted at bit 7 -> sdo_p = 0 asynchronously; state IDLE; the next CNV works normally.
- Full loopback with adc_interface: adc_data_in_p equals sample_data_p for a 32-word ramp 16'h0000..16'h001F; adc_data_received_p pulses 32 times.
